// File: rtl/ecr_pkg.sv
// ecr_pkg: shared types for the ECR client port.
//   ecr_state_t    - 2-bit ECR lock state encoding (11 is outside the enum
//                    but is still treated as a defined value by the client).
//   client_state_t - client FSM states.
//   ecr_is_defined - true when an ECR read value is usable (anything but 00).
package ecr_pkg;

  typedef enum logic [1:0] {
    ECR_UNDEF     = 2'b00,
    ECR_CORRECT   = 2'b01,
    ECR_INCORRECT = 2'b10
  } ecr_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RELEASE,
    ST_RESP
  } client_state_t;

  function automatic logic ecr_is_defined(input logic [1:0] v);
    return v != ECR_UNDEF;
  endfunction

endpackage

// File: rtl/ecr_timeout_counter.sv
// ecr_timeout_counter: saturating cycle counter with a terminal-count flag.
//   clk, rst  - clock, async active-high reset
//   clear     - restart the count at 0 (wins over enable)
//   enable    - count one cycle
//   tc        - count has reached LIMIT (counter holds there)
// Only instantiated when ECR_CLIENT_TIMEOUT_EN is defined.
module ecr_timeout_counter #(
  parameter int LIMIT = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (clear)         count <= '0;
    else if (enable && !tc) count <= count + 1'b1;
  end

  assign tc = (count == W'(LIMIT));

endmodule

// File: rtl/ecr_client_port.sv
// ecr_client_port: turns one read/write command into a lock request on the
// ECR port, waits for a grant (and, for reads, a defined value), releases the
// lock with a single-cycle pulse and returns the result on a response channel.
//   cmd_*   - command channel (valid/ready), write flag, issue ID, write data
//   rsp_*   - response channel (valid/ready), data, timeout flag
//   ecr_*   - lock request lines, payload, release pulse, grant and read data
// Build option: ECR_CLIENT_TIMEOUT_EN bounds the time spent in ST_REQ/ST_WAIT
// to TIMEOUT_CYCLES cycles; without it waits are unbounded and rsp_timeout=0.
module ecr_client_port
  import ecr_pkg::*;
#(
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ID_WIDTH-1:0] cmd_issue_id,
  input  logic [1:0]          cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_data,
  output logic                rsp_timeout,
  output logic                ecr_req_read,
  output logic                ecr_req_write,
  output logic [ID_WIDTH-1:0] ecr_req_issue_id,
  output logic [1:0]          ecr_wdata,
  output logic                ecr_release_lock,
  input  logic                ecr_grant,
  input  logic [1:0]          ecr_rdata
);

  client_state_t       state;
  logic                lat_write;
  logic [ID_WIDTH-1:0] lat_id;
  logic [1:0]          lat_wdata;
  logic                granted;
  logic [1:0]          rsp_data_q;

  logic in_req, hs, done, tmo_hit;

  assign in_req = (state == ST_REQ) || (state == ST_WAIT);
  assign hs     = cmd_valid && (state == ST_IDLE);
  // Writes commit on the first grant; reads need a grant with a defined value.
  assign done   = in_req && ecr_grant &&
                  (lat_write ? (state == ST_REQ) : ecr_is_defined(ecr_rdata));

`ifdef ECR_CLIENT_TIMEOUT_EN
  logic tc;
  logic tmo_q;

  ecr_timeout_counter #(.LIMIT(TIMEOUT_CYCLES - 1)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (hs),
    .enable (in_req),
    .tc     (tc)
  );

  // Completion in the terminal cycle takes priority over the timeout.
  assign tmo_hit = in_req && tc && !done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tmo_q <= 1'b0;
    else if (hs)      tmo_q <= 1'b0;
    else if (tmo_hit) tmo_q <= 1'b1;
  end

  assign rsp_timeout = tmo_q && (state == ST_RESP);
`else
  // The bound has no effect in this build: waits are unbounded.
  assign tmo_hit     = 1'b0 & (TIMEOUT_CYCLES != 0);
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_write  <= 1'b0;
      lat_id     <= '0;
      lat_wdata  <= '0;
      granted    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            lat_write <= cmd_write;
            lat_id    <= cmd_issue_id;
            lat_wdata <= cmd_wdata;
            granted   <= 1'b0;
            state     <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (ecr_grant) granted <= 1'b1;
          if (done) begin
            rsp_data_q <= lat_write ? lat_wdata : ecr_rdata;
            state      <= ST_RELEASE;
          end else if (tmo_hit) begin
            rsp_data_q <= ECR_UNDEF;
            // A lock held now (or earlier) must still be released.
            state      <= (granted || ecr_grant) ? ST_RELEASE : ST_RESP;
          end else if (ecr_grant && state == ST_REQ) begin
            state <= ST_WAIT;  // read granted but value still undefined
          end
        end
        ST_RELEASE: state <= ST_RESP;
        ST_RESP: begin
          if (rsp_ready) begin
            granted <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state; async reset forces them low at once.
  assign cmd_ready        = (state == ST_IDLE) && !rst;
  assign ecr_req_read     = in_req && !lat_write;
  assign ecr_req_write    = in_req && lat_write;
  assign ecr_req_issue_id = lat_id;
  assign ecr_wdata        = lat_wdata;
  assign ecr_release_lock = (state == ST_RELEASE) && granted;
  assign rsp_valid        = (state == ST_RESP);
  assign rsp_data         = rsp_data_q;

endmodule

// File: tb/tb_ecr_client_port.sv
// tb_ecr_client_port: randomized and directed bench for ecr_client_port.
// The ECR side is a per-cycle table of grant/rdata indexed by request cycle;
// expected timing and data are derived from that table directly.
module tb_ecr_client_port;
  import ecr_pkg::*;

  localparam int TMO = 8;
`ifdef ECR_CLIENT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_issue_id;
  logic [1:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_timeout;
  logic [1:0] rsp_data;
  logic       ecr_req_read, ecr_req_write, ecr_release_lock, ecr_grant;
  logic [7:0] ecr_req_issue_id;
  logic [1:0] ecr_wdata, ecr_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  bit         g_arr [64];
  logic [1:0] r_arr [64];

  ecr_client_port #(.ID_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_issue_id     (cmd_issue_id),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_timeout      (rsp_timeout),
    .ecr_req_read     (ecr_req_read),
    .ecr_req_write    (ecr_req_write),
    .ecr_req_issue_id (ecr_req_issue_id),
    .ecr_wdata        (ecr_wdata),
    .ecr_release_lock (ecr_release_lock),
    .ecr_grant        (ecr_grant),
    .ecr_rdata        (ecr_rdata)
  );

  always #5 clk = ~clk;

  // First n cycles present (gp, rp); afterwards grant with rtail.
  task automatic set_pattern(input int n, input bit gp, input logic [1:0] rp,
                             input logic [1:0] rtail);
    for (int i = 0; i < 64; i++) begin
      g_arr[i] = (i < n) ? gp : 1'b1;
      r_arr[i] = (i < n) ? rp : rtail;
    end
  endtask

  task automatic fill_random();
    int gdelay;
    gdelay = $urandom_range(0, 5);
    for (int i = 0; i < 64; i++) begin
      g_arr[i] = (i < gdelay) ? 1'b0 : 1'($urandom % 2);
      r_arr[i] = ($urandom % 3 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (i >= 20) begin
        g_arr[i] = 1'b1;
        r_arr[i] = 2'($urandom_range(1, 3));
      end
    end
  endtask

  // One full command: handshake, request phase driven from g_arr/r_arr,
  // release, response held for 'hold' cycles with rsp_ready low.
  task automatic run_txn(input string nm, input bit wr, input logic [7:0] id,
                         input logic [1:0] wd, input int hold);
    int c, last_req, rsp_at;
    bit tmo, exp_rel, act;
    logic [1:0] exp_data;
    logic [4:0] got5, exp5;
    logic [9:0] got10, exp10;
    logic [6:0] got7, exp7;

    // Reference: completion is the first table cycle with a grant and, for
    // reads, a value other than 00.
    c = 0;
    while (c < 63 && !(g_arr[c] && (wr || r_arr[c] != 2'b00))) c++;
    tmo = TMO_EN && (c >= TMO);
    if (tmo) begin
      last_req = TMO - 1;
      exp_rel  = 1'b0;
      for (int i = 0; i < TMO; i++) if (g_arr[i]) exp_rel = 1'b1;
      exp_data = 2'b00;
    end else begin
      last_req = c;
      exp_rel  = 1'b1;
      exp_data = wr ? wd : r_arr[c];
    end
    rsp_at = last_req + 1 + (exp_rel ? 1 : 0);

    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle cmd_ready got %b want 1", nm, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_issue_id = id; cmd_wdata = wd;
    rsp_ready = 1'b0;

    for (int n = 0; n < rsp_at; n++) begin
      @(negedge clk);
      act  = (n <= last_req);
      got5 = {ecr_req_read, ecr_req_write, ecr_release_lock, rsp_valid, cmd_ready};
      exp5 = {act && !wr, act && wr, exp_rel && (n == last_req + 1), 1'b0, 1'b0};
      n_tests++;
      if (got5 !== exp5) begin
        n_fail++;
        $display("FAIL %s cyc%0d rd/wr/rel/rv/crdy got %b want %b", nm, n, got5, exp5);
      end
      if (act) begin
        got10 = {ecr_req_issue_id, ecr_wdata};
        exp10 = {id, wd};
        n_tests++;
        if (got10 !== exp10) begin
          n_fail++;
          $display("FAIL %s cyc%0d id/wdata got %h want %h", nm, n, got10, exp10);
        end
      end
      // Junk commands while busy must not be accepted.
      cmd_valid    = 1'($urandom % 2);
      cmd_write    = 1'($urandom % 2);
      cmd_issue_id = 8'($urandom);
      cmd_wdata    = 2'($urandom);
      ecr_grant    = act ? g_arr[n] : 1'($urandom % 2);
      ecr_rdata    = act ? r_arr[n] : 2'($urandom);
    end

    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      got7 = {rsp_valid, rsp_data, rsp_timeout, cmd_ready, ecr_release_lock,
              ecr_req_read | ecr_req_write};
      exp7 = {1'b1, exp_data, tmo, 1'b0, 1'b0, 1'b0};
      n_tests++;
      if (got7 !== exp7) begin
        n_fail++;
        $display("FAIL %s resp%0d rv/data/tmo/crdy/rel/req got %b want %b", nm, k, got7, exp7);
      end
      cmd_valid = (k < hold) ? 1'($urandom % 2) : 1'b0;
      rsp_ready = (k == hold);
      ecr_grant = 1'b0;
    end

    @(negedge clk);
    n_tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s after-resp rv/crdy got %b want 01", nm, {rsp_valid, cmd_ready});
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_issue_id = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; ecr_grant = 1'b0; ecr_rdata = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_timeout, ecr_req_read, ecr_req_write,
         ecr_req_issue_id, ecr_wdata, ecr_release_lock} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset outputs not zero rv=%b rd=%b wr=%b rel=%b id=%h",
               rsp_valid, ecr_req_read, ecr_req_write, ecr_release_lock, ecr_req_issue_id);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release cmd_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_issue_id = 8'hA7; cmd_wdata = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0; ecr_grant = 1'b1; ecr_rdata = 2'b00;
    repeat (3) @(negedge clk);  // granted, read value still 00 -> waiting
    n_tests++;
    if (ecr_req_read !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid pre req_read got %b want 1", ecr_req_read);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_timeout, ecr_req_read, ecr_req_write,
         ecr_req_issue_id, ecr_wdata, ecr_release_lock} !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid async outputs not zero rd=%b rel=%b id=%h",
               ecr_req_read, ecr_release_lock, ecr_req_issue_id);
    end
    ecr_rdata = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      n_tests++;
      if (ecr_release_lock !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid release during reset got %b want 0", ecr_release_lock);
      end
    end
    ecr_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_ready, ecr_release_lock, ecr_req_read, rsp_valid} !== 4'b1000) begin
        n_fail++;
        $display("FAIL rst_mid after release crdy/rel/rd/rv got %b want 1000",
                 {cmd_ready, ecr_release_lock, ecr_req_read, rsp_valid});
      end
    end
    // Fresh command afterwards must carry its own data only.
    set_pattern(1, 1'b1, 2'b00, 2'b01);
    run_txn("post_reset", 1'b1, 8'h3C, 2'b11, 0);
  endtask

  task automatic test_directed();
    set_pattern(0, 1'b0, 2'b00, 2'b10);
    run_txn("write_min_latency", 1'b1, 8'd5, 2'b01, 0);
    set_pattern(4, 1'b1, 2'b00, 2'b10);
    run_txn("read_wait_4", 1'b0, 8'h21, 2'b00, 0);
    set_pattern(10, 1'b0, 2'b10, 2'b01);
    run_txn("read_grant_withheld", 1'b0, 8'h44, 2'b01, 0);
    set_pattern(2, 1'b0, 2'b00, 2'b10);
    run_txn("write_rsp_hold5", 1'b1, 8'h99, 2'b10, 5);
    set_pattern(0, 1'b0, 2'b00, 2'b11);
    run_txn("read_value_11", 1'b0, 8'h0F, 2'b00, 1);
    // Grant drops while waiting; the request must persist.
    set_pattern(0, 1'b0, 2'b00, 2'b01);
    g_arr[0] = 1'b1; r_arr[0] = 2'b00;
    g_arr[1] = 1'b0; g_arr[2] = 1'b0; g_arr[3] = 1'b1; r_arr[3] = 2'b00;
    g_arr[4] = 1'b0; r_arr[4] = 2'b10;
    run_txn("read_grant_drop", 1'b0, 8'h77, 2'b00, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      fill_random();
      run_txn($sformatf("rand%0d", t), 1'($urandom % 2), 8'($urandom),
              2'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_timeout();
    set_pattern(64, 1'b0, 2'b00, 2'b00);
    run_txn("tmo_no_grant", 1'b0, 8'h12, 2'b00, 0);
    set_pattern(64, 1'b1, 2'b00, 2'b00);
    run_txn("tmo_grant_undef", 1'b0, 8'h34, 2'b00, 1);
    set_pattern(64, 1'b0, 2'b00, 2'b00);
    run_txn("tmo_write", 1'b1, 8'h56, 2'b01, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
`ifdef ECR_CLIENT_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecr_client_port.md
ECR_CLIENT_PORT -- requirements
Module: ecr_client_port

Interface
REQ-001 Parameter ID_WIDTH, default 8, width of the issue ID.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, maximum cycles in ST_REQ/ST_WAIT; used only with ECR_CLIENT_TIMEOUT_EN.
REQ-003 clk  input  1  rising-edge clock; one clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid is also high.
REQ-007 cmd_write  input  1  1=write, 0=read.
REQ-008 cmd_issue_id  input  ID_WIDTH  issue ID of the requesting instruction.
REQ-009 cmd_wdata  input  2  state to write.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid is also high.
REQ-012 rsp_data  output  2  read value, or written value for writes.
REQ-013 rsp_timeout  output  1  request aborted; tied 0 without the macro.
REQ-014 ecr_req_read, ecr_req_write  output  1 each  lock request lines to the ECR port.
REQ-015 ecr_req_issue_id  output  ID_WIDTH; ecr_wdata  output  2  request payload.
REQ-016 ecr_release_lock  output  1  single-cycle lock release pulse.
REQ-017 ecr_grant  input  1; ecr_rdata  input  2  lock grant and ECR state (00 Undefined, 01 Correct, 10 Incorrect).

Function
REQ-018 The FSM SHALL have states ST_IDLE, ST_REQ, ST_WAIT, ST_RELEASE, ST_RESP.
REQ-019 cmd_ready SHALL be high only in ST_IDLE; a handshake SHALL latch cmd_write, cmd_issue_id and cmd_wdata and move the FSM to ST_REQ.
REQ-020 In ST_REQ and ST_WAIT, exactly one of ecr_req_read/ecr_req_write SHALL be high, selected by the latched cmd_write, with the latched ID and wdata held stable.
REQ-021 Write: the first cycle with ecr_grant high in ST_REQ SHALL be the commit cycle; the next state SHALL be ST_RELEASE, and rsp_data SHALL be the latched wdata.
REQ-022 Read: in a cycle with ecr_grant high and ecr_rdata != 00, the block SHALL capture ecr_rdata into rsp_data and go to ST_RELEASE.
REQ-023 Read: if ecr_grant is high and ecr_rdata == 00, the block SHALL go to ST_WAIT, keep the request asserted, and capture on the first cycle with ecr_grant high and ecr_rdata != 00.
REQ-024 A value of 11 on ecr_rdata SHALL count as defined and SHALL be returned unchanged.
REQ-025 ST_RELEASE SHALL last one cycle, with ecr_release_lock=1 and both request lines low; the next state SHALL be ST_RESP.
REQ-026 ST_RESP SHALL hold rsp_valid=1 and rsp_data stable until rsp_ready is high, then return to ST_IDLE; there SHALL be no bypass from ST_RESP to ST_IDLE.
REQ-027 Minimum latency, handshake to rsp_valid, SHALL be 3 cycles when the grant arrives in the first ST_REQ cycle.
REQ-028 ecr_release_lock SHALL never be asserted unless a grant was sampled for the current command (granted flag).
REQ-029 Grant deassertion while in ST_WAIT SHALL NOT abort the request; the block keeps waiting.

Reset
REQ-030 While rst=1, the FSM SHALL be in ST_IDLE, and all outputs SHALL be 0 except cmd_ready, which SHALL be 1 after reset release.
REQ-031 Reset mid-operation SHALL discard the latched command and the granted flag and SHALL NOT emit a release pulse.

Configuration
REQ-032 With ECR_CLIENT_TIMEOUT_EN defined, a counter SHALL clear on entry to ST_REQ and increment each cycle in ST_REQ/ST_WAIT.
REQ-033 With the macro, when the counter reaches TIMEOUT_CYCLES-1 without completion, the block SHALL go to ST_RELEASE if the granted flag is set, otherwise directly to ST_RESP, with rsp_timeout=1 and rsp_data=00.
REQ-034 Without the macro, the counter SHALL be absent, rsp_timeout SHALL be constant 0, and waits SHALL be unbounded.

Structure
REQ-035 Package ecr_pkg SHALL hold ecr_state_t (ECR_UNDEF=00, ECR_CORRECT=01, ECR_INCORRECT=10) and the client FSM state enum.
REQ-036 The timeout counter SHALL be sub-module ecr_timeout_counter (clear, enable, terminal-count output); it SHALL be instantiated only under the macro.

Verification
REQ-037 Write cmd id=5, wdata=01; grant in the first ST_REQ cycle -> ecr_req_write for 1 cycle, release pulse the next cycle, rsp_valid with rsp_data=01 at cycle 3.
REQ-038 Read cmd; grant high, rdata=00 for 4 cycles, then 10 -> request held 5 cycles, rsp_data=10, exactly one release pulse.
REQ-039 Read cmd; grant withheld 10 cycles -> request lines stable, no release pulse, cmd_ready=0 throughout.
REQ-040 rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, no new cmd accepted.
REQ-041 rst asserted in ST_WAIT -> all outputs 0 asynchronously, no release pulse, cmd_ready=1 after deassertion.
REQ-042 With the macro and TIMEOUT_CYCLES=8, grant never arrives -> rsp_timeout=1, rsp_data=00, no release pulse; with grant but rdata=00 -> release pulse, then timeout response.
